// File: rtl/pe_row_sched.sv
// Row scheduler for the sparse 1-D conv PE: header + nnz entries per row, one flush step per row.
// Latency: start to first read 1 cycle, row = nnz+3 cycles, done 1 cycle after the last flush.
// Backpressure: none; start is ignored while busy, pe_in passes in_data through combinationally.
module pe_row_sched #(
    parameter int ADDR_WIDTH_IN = 5,
    parameter int ADDR_WIDTH_O  = 5,
    parameter int FILTER_SIZE   = 5,
    parameter int MAX_NNZ       = 28,
    parameter int ROW_W         = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROW_W-1:0]         num_rows,
    input  logic [15:0]              in_data,
    output logic [ADDR_WIDTH_IN-1:0] in_addr,
    output logic                     in_en,
    output logic [15:0]              pe_in,
    output logic [4:0]               pe_cnt,
    input  logic [2:0]               pop_num,
    output logic [ADDR_WIDTH_O-1:0]  out_addr,
    output logic                     out_we,
    output logic                     row_fini,
    output logic                     busy,
    output logic                     done,
    output logic                     err_len
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRIME  = 3'd1;
    localparam logic [2:0] S_HDR    = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [7:0]              MAX_NNZ_W  = 8'(MAX_NNZ);
    localparam logic [ADDR_WIDTH_O-1:0] FILTER_INC = ADDR_WIDTH_O'(FILTER_SIZE);

    logic [2:0]               state;
    logic [ADDR_WIDTH_IN-1:0] rd_ptr;
    logic [7:0]               nnz;
    logic [7:0]               k;
    logic [ROW_W-1:0]         rows_left;
    logic                     err_q;

    logic [7:0] nnz_raw;
    logic [7:0] nnz_hdr;
    logic       hdr_clamp;

    assign nnz_raw   = in_data[15:8];
    assign hdr_clamp = (nnz_raw > MAX_NNZ_W);
    assign nnz_hdr   = hdr_clamp ? MAX_NNZ_W : nnz_raw;

    assign busy    = (state != S_IDLE);
    assign in_addr = rd_ptr;
    // The clamp is visible in the header cycle itself, then held by err_q.
    assign err_len = err_q | ((state == S_HDR) && hdr_clamp);

    always_comb begin
        in_en    = 1'b0;
        pe_in    = 16'd0;
        pe_cnt   = 5'd0;
        out_we   = 1'b0;
        row_fini = 1'b0;
        done     = 1'b0;
        case (state)
            S_PRIME: begin
                in_en = 1'b1;
            end
            S_HDR: begin
                pe_cnt = 5'd1;
                pe_in  = in_data;
                in_en  = (nnz_hdr != 8'd0);
            end
            S_STREAM: begin
                pe_cnt = 5'(k + 8'd1);
                pe_in  = in_data;
                in_en  = (k < nnz);
                out_we = (k >= 8'd2);
            end
            S_FLUSH: begin
                pe_cnt   = 5'(nnz + 8'd2);
                row_fini = 1'b1;
                out_we   = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            nnz       <= 8'd0;
            k         <= 8'd0;
            rows_left <= '0;
            out_addr  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (num_rows != '0) begin
                            rd_ptr    <= '0;
                            out_addr  <= '0;
                            rows_left <= num_rows;
                            state     <= S_PRIME;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_PRIME: begin
                    rd_ptr <= rd_ptr + ADDR_WIDTH_IN'(1);
                    state  <= S_HDR;
                end
                S_HDR: begin
                    nnz <= nnz_hdr;
                    if (hdr_clamp) begin
                        err_q <= 1'b1;
                    end
                    if (nnz_hdr != 8'd0) begin
                        rd_ptr <= rd_ptr + ADDR_WIDTH_IN'(1);
                        k      <= 8'd1;
                        state  <= S_STREAM;
                    end else begin
                        state <= S_FLUSH;
                    end
                end
                S_STREAM: begin
                    if (in_en) begin
                        rd_ptr <= rd_ptr + ADDR_WIDTH_IN'(1);
                    end
                    if (out_we) begin
                        out_addr <= out_addr + ADDR_WIDTH_O'(pop_num);
                    end
                    if (k == nnz) begin
                        state <= S_FLUSH;
                    end else begin
                        k <= k + 8'd1;
                    end
                end
                S_FLUSH: begin
                    out_addr  <= out_addr + FILTER_INC;
                    rows_left <= rows_left - ROW_W'(1);
                    state     <= (rows_left > ROW_W'(1)) ? S_PRIME : S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
